cpu_if_fq: RTL

- Parametrised successor to the single-slot fetch stage: a fetch unit with a QDEPTH-entry instruction queue between the icache and the decoder.
- Drives the PC to the icache and captures hits. Byte-swaps each fetched word and predecodes jumps and branches so it can stop fetching down a speculative path.
- Accepts redirects from the branch unit and NJMP ALU jump sources. A redirect flushes the queue.
- The decoder consumes instructions through a valid/ready handshake instead of a one-cycle issue pulse.

---
 rtl/cpu_defs.sv | 40 ++++
 rtl/cpu_if_queue.sv | 73 +++++++
 rtl/cpu_if_fq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared opcode constants, fetch FSM encoding and predecode helpers
//
// Purpose : constants and small pure functions shared by the fetch unit and
//           its instruction queue.
// Ports   : none (package).

package cpu_defs;

   // RV32 opcode / funct3 values needed by the fetch predecoder
   localparam logic [6:0]  OPC_JAL     = 7'b1101111;
   localparam logic [6:0]  OPC_JALR    = 7'b1100111;
   localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;
   localparam logic [2:0]  FUNCT3_JALR = 3'b000;
   localparam logic [31:0] OP_NOP      = 32'h0000_0013;

   // Fetch FSM state encoding
   localparam logic [1:0] FS_RUN      = 2'd0;
   localparam logic [1:0] FS_WAIT_JMP = 2'd1;
   localparam logic [1:0] FS_WAIT_BR  = 2'd2;

   typedef struct packed {
      logic is_jmp;
      logic is_br;
   } predec_t;

   // Reverse the byte order of a 32-bit word (memory order <-> instruction order)
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Classify an instruction as an unconditional jump or a conditional branch
   function automatic predec_t predecode(input logic [31:0] inst);
      predec_t p;
      p.is_br  = (inst[6:0] == OPC_BRANCH);
      p.is_jmp = (inst[6:0] == OPC_JAL) ||
                 ((inst[6:0] == OPC_JALR) && (inst[14:12] == FUNCT3_JALR));
      return p;
   endfunction

endpackage

// File: rtl/cpu_if_queue.sv
// rtl/cpu_if_queue.sv - parametrised circular FIFO holding fetched {pc, inst} entries
//
// Purpose : DEPTH-entry circular buffer with synchronous flush. DEPTH must be
//           a power of two (pointers wrap naturally) and at least 2.
// Ports   : clk, rst_n   clock and asynchronous active-low reset
//           push, wdata  write wdata at the tail (ignored when full)
//           pop          advance the head (ignored when empty)
//           flush        empty the queue on the next edge; wins over push/pop
//           rdata        head entry, combinational
//           count        occupancy, 0..DEPTH
//           full, empty  occupancy flags

module cpu_if_queue
   import cpu_defs::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_FULL);
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         // Simultaneous push and pop leaves the occupancy unchanged
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: an entry is only visible once count covers it
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/cpu_if_fq.sv
// rtl/cpu_if_fq.sv - instruction fetch unit with a QDEPTH-entry queue to the decoder
//
// Purpose : drives the PC to the icache, captures hits into a queue, stops
//           fetching after a predecoded jump/branch until a redirect arrives,
//           and hands instructions to the decoder over valid/ready.
// Ports   : clk, rst_n           clock, asynchronous active-low reset
//           rdy                  global enable, low freezes everything
//           ic_req_out/ic_pc_out fetch request and address to the icache
//           ic_hit/ic_inst       same-cycle hit and word (memory byte order)
//           jmp_en/jmp_addr      NJMP ALU jump redirect sources
//           br_en/br_addr        branch-resolution redirect
//           dec_valid/dec_pc/dec_inst/dec_ready  decoder handshake
//           q_count_out          queue occupancy

module cpu_if_fq
   import cpu_defs::*;
#(
   parameter int              XLEN     = 32,
   parameter int              QDEPTH   = 4,
   parameter int              NJMP     = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter bit              BSWAP    = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rdy,
   output logic                     ic_req_out,
   output logic [XLEN-1:0]          ic_pc_out,
   input  logic                     ic_hit,
   input  logic [31:0]              ic_inst,
   input  logic [NJMP-1:0]          jmp_en,
   input  logic [NJMP*XLEN-1:0]     jmp_addr,
   input  logic                     br_en,
   input  logic [XLEN-1:0]          br_addr,
   output logic                     dec_valid,
   output logic [XLEN-1:0]          dec_pc,
   output logic [31:0]              dec_inst,
   input  logic                     dec_ready,
   output logic [$clog2(QDEPTH):0]  q_count_out
);

   localparam int QW = XLEN + 32;

   logic [XLEN-1:0]         pc_q, pc_d;
   logic [1:0]              state_q, state_d;
   logic [31:0]             inst;
   predec_t                 pd;
   logic                    redirect;
   logic [XLEN-1:0]         jmp_target, redir_target;
   logic                    req_int, dv_int, push, pop;
   logic [QW-1:0]           q_rdata;
   logic [$clog2(QDEPTH):0] q_count;
   logic                    q_full, q_empty;

   assign inst = BSWAP ? bswap32(ic_inst) : ic_inst;
   assign pd   = predecode(inst);

   // Lowest-index asserted jump source wins: scan downwards so it is written last
   always_comb begin
      jmp_target = '0;
      for (int i = NJMP - 1; i >= 0; i--) begin
         if (jmp_en[i]) jmp_target = jmp_addr[i*XLEN +: XLEN];
      end
   end

   assign redirect     = rdy & (br_en | (|jmp_en));
   assign redir_target = br_en ? br_addr : jmp_target;

   assign req_int = rdy & (state_q == FS_RUN) & ~q_full & ~redirect;
   assign push    = req_int & ic_hit;
   assign dv_int  = rdy & ~q_empty & ~redirect;
   assign pop     = dv_int & dec_ready;

   // Handshake outputs are forced low while reset is asserted, even when rdy is high
   assign ic_req_out  = req_int & rst_n;
   assign dec_valid   = dv_int & rst_n;
   assign ic_pc_out   = pc_q;
   assign q_count_out = q_count;
   // Head contents are masked when empty so stale storage never leaks out
   assign dec_pc      = q_empty ? '0 : q_rdata[QW-1:32];
   assign dec_inst    = q_empty ? '0 : q_rdata[31:0];

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if (redirect) begin
         pc_d    = redir_target;
         state_d = FS_RUN;
      end else if (push) begin
         pc_d = pc_q + XLEN'(4);
         // Stop fetching down a speculative path until the redirect resolves it
         if (pd.is_br)       state_d = FS_WAIT_BR;
         else if (pd.is_jmp) state_d = FS_WAIT_JMP;
         else                state_d = FS_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         state_q <= FS_RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   cpu_if_queue #(
      .WIDTH (QW),
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({pc_q, inst}),
      .pop   (pop),
      .flush (redirect),
      .rdata (q_rdata),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );

endmodule
